// File: rtl/uart_hex_resp_pkg.sv
// uart_hex_resp_pkg
// Shared types and helpers for the hex reply encoder (uart_hex_resp_tx):
//   - state_t      : reply sequencer states
//   - ASCII_*      : character constants used to build the reply
//   - nib_to_ascii : 4-bit value -> uppercase ASCII hex digit
package uart_hex_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GUARD,
        WAIT
    } state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    // 'A' minus 10, so that ASCII_A_M10 + 10 == 'A'
    localparam logic [7:0] ASCII_A_M10 = 8'h37;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A_M10 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_hex_resp_tx.sv
// uart_hex_resp_tx
// Serialises a read-data word as an ASCII reply ("D" followed by the word in
// uppercase hex, MSB nibble first) into a byte-wide UART transmitter.
//
// Optional build macro: UART_HEX_RESP_CRLF_EN -- when defined, a CR LF pair
// is appended after the last hex digit.
//
// Ports:
//   clk         system clock
//   i_reset_n   asynchronous reset, active-low
//   in_data     read-data word to send (captured on acceptance)
//   in_valid    request, accepted only while out_ready=1
//   out_ready   high when idle and able to accept a request
//   in_BUSY     UART TX busy flag
//   out_w_data  byte presented to the UART TX
//   out_valid   one-cycle send strobe to the UART TX
//   out_done    one-cycle pulse when the whole reply has been transmitted
module uart_hex_resp_tx
    import uart_hex_resp_pkg::*;
#(
    parameter int         DATA_W      = 16,
    parameter logic [7:0] PREFIX_CHAR = 8'h44
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              out_ready,
    input  logic              in_BUSY,
    output logic [7:0]        out_w_data,
    output logic              out_valid,
    output logic              out_done
);

    localparam int ND = DATA_W / 4;
`ifdef UART_HEX_RESP_CRLF_EN
    localparam int NCH = ND + 3;
`else
    localparam int NCH = ND + 1;
`endif
    localparam int IDX_W = $clog2(NCH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] data_reg;

    logic [7:0]        digit_chars [ND];
    logic [7:0]        char_next;

    // One ASCII digit per nibble; digit 0 is the most significant nibble.
    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_digit
            assign digit_chars[gi] = nib_to_ascii(data_reg[DATA_W-1-4*gi -: 4]);
        end
    endgenerate

    // Character for the current index: prefix, ND digits, optional CR LF.
    always_comb begin
        char_next = PREFIX_CHAR;
        for (int i = 0; i < ND; i++) begin
            if (idx_reg == IDX_W'(i + 1)) begin
                char_next = digit_chars[i];
            end
        end
`ifdef UART_HEX_RESP_CRLF_EN
        if (idx_reg == IDX_W'(ND + 1)) begin
            char_next = ASCII_CR;
        end
        if (idx_reg == IDX_W'(ND + 2)) begin
            char_next = ASCII_LF;
        end
`endif
    end

    // Reply sequencer. out_ready is a register so that it is low both while a
    // reply is in flight and during the out_done cycle; it rises the cycle
    // after the sequencer has returned to IDLE.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            data_reg   <= '0;
            out_w_data <= '0;
            out_valid  <= 1'b0;
            out_done   <= 1'b0;
            out_ready  <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            out_done  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (out_ready && in_valid) begin
                        data_reg  <= in_data;
                        idx_reg   <= '0;
                        out_ready <= 1'b0;
                        state_reg <= LOAD;
                    end else begin
                        out_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    out_w_data <= char_next;
                    state_reg  <= SEND;
                end
                SEND: begin
                    if (!in_BUSY) begin
                        out_valid <= 1'b1;
                        state_reg <= GUARD;
                    end
                end
                GUARD: begin
                    // Give the UART a cycle to raise BUSY for this byte.
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (!in_BUSY) begin
                        if (idx_reg == LAST_IDX) begin
                            out_done  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_resp_tx.sv
// tb_uart_hex_resp_tx
// Self-checking bench for uart_hex_resp_tx (DATA_W=16). A UART TX model
// raises BUSY for a configurable number of cycles after each strobe; every
// reply is compared against the expected character sequence.
module tb_uart_hex_resp_tx;

    localparam int DATA_W = 16;
    localparam int ND     = DATA_W / 4;
`ifdef UART_HEX_RESP_CRLF_EN
    localparam int NCH = ND + 3;
`else
    localparam int NCH = ND + 1;
`endif

    logic              clk = 1'b0;
    logic              i_reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              out_ready;
    logic              in_BUSY;
    logic [7:0]        out_w_data;
    logic              out_valid;
    logic              out_done;

    uart_hex_resp_tx #(
        .DATA_W      (DATA_W),
        .PREFIX_CHAR (8'h44)
    ) dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_BUSY    (in_BUSY),
        .out_w_data (out_w_data),
        .out_valid  (out_valid),
        .out_done   (out_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- UART TX model and output monitor ----------------
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         done_cnt   = 0;
    int         done_cyc   = 0;
    int         fall_cyc   = 0;
    int         busy_cnt   = 0;
    int         busy_len   = 3;
    logic       force_busy = 1'b0;
    logic       prev_valid = 1'b0;

    initial begin
        logic new_busy;
        in_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (!i_reset_n) begin
                busy_cnt   = 0;
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    check("strobe_while_busy", 32'(in_BUSY), 32'd0);
                    check("strobe_width", 32'(prev_valid), 32'd0);
                    got_q.push_back(out_w_data);
                    got_cyc.push_back(cyc);
                    busy_cnt = busy_len;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                end
                prev_valid = out_valid;
                if (out_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            new_busy = (busy_cnt > 0) || force_busy;
            if (in_BUSY && !new_busy) fall_cyc = cyc;
            in_BUSY = new_busy;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];

    function automatic void add_term();
`ifdef UART_HEX_RESP_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endfunction

    // 'D', then hex digits most significant first, uppercase, then terminator.
    function automatic void build_exp(input logic [DATA_W-1:0] d);
        exp_q.delete();
        exp_q.push_back(8'h44);
        for (int i = ND - 1; i >= 0; i--) begin
            int n;
            n = int'((d >> (4 * i)) & 16'hF);
            if (n < 10) exp_q.push_back(8'(48 + n));
            else        exp_q.push_back(8'(65 + n - 10));
        end
        add_term();
    endfunction

    // ---------------- transaction helpers ----------------
    int accept_cyc  = 0;
    int done_before = 0;

    task automatic start_req(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!out_ready && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!out_ready) check("ready_timeout", 32'(out_ready), 32'd1);
        got_q.delete();
        got_cyc.delete();
        done_before = done_cnt;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk); #1;
        in_valid   = 1'b0;
        accept_cyc = cyc;
        in_data    = 16'($urandom);
        check("ready_drop", 32'(out_ready), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == done_before && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_seen", 32'(done_cnt - done_before), 32'd1);
    endtask

    task automatic verify(input string name, input logic [DATA_W-1:0] d,
                          input bit chk_lat, input bit trail);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        if (chk_lat && got_cyc.size() > 0) begin
            check({name, "_first_lat"}, 32'(got_cyc[0] - accept_cyc), 32'd2);
        end
        check({name, "_done_lat"}, 32'(done_cyc - fall_cyc), 32'd1);
        $display("reply %s data=%04h bytes=%0d done=%0d", name, d, got_q.size(), done_cnt - done_before);
        if (trail) begin
            repeat (6) @(negedge clk);
            #1;
            check({name, "_no_extra"}, 32'(got_q.size()), 32'(exp_q.size()));
            check({name, "_single_done"}, 32'(done_cnt - done_before), 32'd1);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        int                blen;
        logic [39:0]       exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        int d0;
        logic [DATA_W-1:0] rd;

        vecs[0] = '{data: 16'h3410, blen: 100, exp: "D3410"};
        vecs[1] = '{data: 16'hABCF, blen: 4,   exp: "DABCF"};
        vecs[2] = '{data: 16'h0000, blen: 1,   exp: "D0000"};
        vecs[3] = '{data: 16'hFFFF, blen: 2,   exp: "DFFFF"};
        vecs[4] = '{data: 16'h9E5D, blen: 7,   exp: "D9E5D"};

        i_reset_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(out_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_wdata", 32'(out_w_data), 32'd0);
        i_reset_n = 1'b1;

        // Table-driven replies
        for (int v = 0; v < 5; v++) begin
            busy_len = vecs[v].blen;
            exp_q.delete();
            for (int i = 0; i < 5; i++) exp_q.push_back(vecs[v].exp[39-8*i -: 8]);
            add_term();
            start_req(vecs[v].data);
            wait_done();
            verify($sformatf("vec%0d", v), vecs[v].data, 1'b1, 1'b1);
        end

        // Request during an active reply is ignored
        busy_len = 20;
        build_exp(16'h3410);
        start_req(16'h3410);
        n = 0;
        while (got_q.size() < 1 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        in_data  = 16'h1111;
        in_valid = 1'b1;
        check("busy_req_ready", 32'(out_ready), 32'd0);
        @(negedge clk); #1;
        in_valid = 1'b0;
        check("busy_req_ready2", 32'(out_ready), 32'd0);
        wait_done();
        verify("ignore", 16'h3410, 1'b1, 1'b1);

        // BUSY held high before acceptance stalls the first strobe
        busy_len   = 3;
        force_busy = 1'b1;
        build_exp(16'h0009);
        start_req(16'h0009);
        repeat (10) @(negedge clk);
        #1;
        check("stall_no_strobe", 32'(got_q.size()), 32'd0);
        force_busy = 1'b0;
        wait_done();
        verify("stall", 16'h0009, 1'b0, 1'b1);

        // Request in the out_done cycle is ignored, accepted the cycle after
        busy_len = 2;
        build_exp(16'h5A5A);
        start_req(16'h5A5A);
        wait_done();
        verify("pre_done", 16'h5A5A, 1'b1, 1'b0);
        in_data  = 16'hC0DE;
        in_valid = 1'b1;
        @(negedge clk); #1;
        check("done_cycle_ignored", 32'(out_ready), 32'd1);
        got_q.delete();
        got_cyc.delete();
        done_before = done_cnt;
        @(negedge clk); #1;
        in_valid   = 1'b0;
        accept_cyc = cyc;
        check("after_done_accept", 32'(out_ready), 32'd0);
        build_exp(16'hC0DE);
        wait_done();
        verify("post_done", 16'hC0DE, 1'b1, 1'b1);

        // Reset after the second strobe aborts the reply
        busy_len = 5;
        build_exp(16'h3410);
        start_req(16'h3410);
        n = 0;
        while (got_q.size() < 2 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check("abort_at_byte2", 32'(got_q.size()), 32'd2);
        check("abort_strobe_live", 32'(out_valid), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_wdata", 32'(out_w_data), 32'd0);
        check("abort_done", 32'(out_done), 32'd0);
        check("abort_ready", 32'(out_ready), 32'd1);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        #1;
        i_reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("abort_no_strobe", 32'(got_q.size()), 32'd2);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        build_exp(16'h0001);
        start_req(16'h0001);
        wait_done();
        verify("after_abort", 16'h0001, 1'b1, 1'b1);

        // Randomised replies against the reference model
        for (int r = 0; r < 15; r++) begin
            rd       = 16'($urandom);
            busy_len = $urandom_range(1, 6);
            build_exp(rd);
            start_req(rd);
            wait_done();
            verify($sformatf("rnd%0d", r), rd, 1'b1, 1'b1);
        end

        check("nch_const", 32'(exp_q.size()), 32'(NCH));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
